// File: rtl/gf2_poly_divider.sv
// rtl/gf2_poly_divider.sv - bit-serial GF(2)[x] long divider (quotient, remainder, divide-by-zero flag)
// Finds the divisor degree one bit per cycle, then shifts the dividend in MSB first, one bit per cycle.
module gf2_poly_divider #(
  parameter int N_WIDTH = 512,
  parameter int D_WIDTH = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N_WIDTH-1:0] dividend,
  input  logic [D_WIDTH-1:0] divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N_WIDTH-1:0] quotient,
  output logic [D_WIDTH-2:0] remainder,
  output logic               div_by_zero
);

  localparam int IW = $clog2(D_WIDTH);
  localparam int CW = $clog2(N_WIDTH);
  localparam logic [IW-1:0] IDX_TOP = IW'(D_WIDTH - 1);
  localparam logic [CW-1:0] CNT_TOP = CW'(N_WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] NORM = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]         state;
  logic [N_WIDTH-1:0] dvd;
  logic [D_WIDTH-1:0] dvs;
  logic [IW-1:0]      idx;
  logic [IW-1:0]      deg;
  logic [CW-1:0]      cnt;
  logic [D_WIDTH-1:0] t;
  logic               sub;
  logic [D_WIDTH-2:0] r_next;

  // Bits of t at and above deg cancel against the divisor, so only the low D_WIDTH-1 bits are kept.
  always_comb begin
    t      = {remainder, dvd[cnt]};
    sub    = t[deg];
    r_next = t[D_WIDTH-2:0] ^ (sub ? dvs[D_WIDTH-2:0] : '0);
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      dvd         <= '0;
      dvs         <= '0;
      idx         <= '0;
      deg         <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dvd         <= dividend;
            dvs         <= divisor;
            idx         <= IDX_TOP;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            state       <= NORM;
          end
        end
        NORM: begin
          if (dvs[idx]) begin
            deg   <= idx;
            cnt   <= CNT_TOP;
            state <= DIV;
          end else if (idx == '0) begin
            div_by_zero <= 1'b1;
            state       <= DONE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        DIV: begin
          remainder <= r_next;
          quotient  <= {quotient[N_WIDTH-2:0], sub};
          if (cnt == '0) state <= DONE;
          else           cnt   <= cnt - 1'b1;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gf2_poly_divider.sv
// tb/tb_gf2_poly_divider.sv - directed and clmul-based checks of gf2_poly_divider
module tb_gf2_poly_divider;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [511:0] dividend;
  logic [255:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [511:0] quotient;
  logic [254:0] remainder;
  logic         div_by_zero;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  gf2_poly_divider #(.N_WIDTH(512), .D_WIDTH(256)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
    .out_ready(out_ready), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] clmul(input logic [255:0] a, input logic [255:0] b);
    logic [511:0] acc = '0;
    for (int i = 0; i < 256; i++)
      if (b[i]) acc = acc ^ ({256'd0, a} << i);
    return acc;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [255:0] low_mask(input int nbits);
    logic [255:0] one = 256'd1;
    if (nbits >= 256) return '1;
    return (one << nbits) - one;
  endfunction

  task automatic start_op(input logic [511:0] dd, input logic [255:0] ds);
    check("in_ready_before_accept", {511'd0, in_ready}, 512'd1);
    in_valid = 1'b1;
    dividend = dd;
    divisor  = ds;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 2000) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) check("timeout_out_valid", 512'd0, 512'd1);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("in_ready_after_consume", {511'd0, in_ready}, 512'd1);
    check("out_valid_after_consume", {511'd0, out_valid}, 512'd0);
  endtask

  task automatic check_result(input string tag, input logic [511:0] eq, input logic [254:0] er,
                              input logic edz, input int lat, input int elat);
    check({tag, "_quotient"}, quotient, eq);
    check({tag, "_remainder"}, {257'd0, remainder}, {257'd0, er});
    check({tag, "_div_by_zero"}, {511'd0, div_by_zero}, {511'd0, edz});
    check({tag, "_latency"}, 512'(lat), 512'(elat));
  endtask

  task automatic do_op(input string tag, input logic [511:0] dd, input logic [255:0] ds,
                       input logic [511:0] eq, input logic [254:0] er, input logic edz, input int elat);
    int lat;
    start_op(dd, ds);
    wait_done(lat);
    check_result(tag, eq, er, edz, lat, elat);
    consume();
  endtask

  initial begin
    logic [511:0] rd;
    logic [255:0] a, b, r;
    int db, da, lat;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", {511'd0, in_ready}, 512'd1);
    check("reset_out_valid", {511'd0, out_valid}, 512'd0);
    check("reset_quotient", quotient, 512'd0);
    check("reset_remainder", {257'd0, remainder}, 512'd0);
    check("reset_div_by_zero", {511'd0, div_by_zero}, 512'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // (x+1)^2 / (x+1), then (x^3+x+1) / (x^2+x+1)
    do_op("t1", 512'h5, 256'h3, 512'd3, 255'd0, 1'b0, 767);
    do_op("t2", 512'hB, 256'h7, 512'd3, 255'd2, 1'b0, 766);

    rd = {rand256(), rand256()};
    do_op("t3_unity", rd, 256'd1, rd, 255'd0, 1'b0, 768);
    do_op("t3_zero", rd, 256'd0, 512'd0, 255'd0, 1'b1, 256);
    do_op("t3_top_deg", 512'h1, {1'b1, 255'd0}, 512'd0, 255'd1, 1'b0, 513);

    start_op(512'h5, 256'h3);
    wait_done(lat);
    check_result("t4_first", 512'd3, 255'd0, 1'b0, lat, 767);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("t4_hold_out_valid", {511'd0, out_valid}, 512'd1);
      check("t4_hold_in_ready", {511'd0, in_ready}, 512'd0);
      check("t4_hold_quotient", quotient, 512'd3);
    end
    consume();
    do_op("t4_second", 512'hB, 256'h7, 512'd3, 255'd2, 1'b0, 766);

    start_op(512'hB, 256'h7);
    repeat (254 + 100) @(posedge clk);
    #1;
    check("t5_busy_in_ready", {511'd0, in_ready}, 512'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t5_reset_in_ready", {511'd0, in_ready}, 512'd1);
    check("t5_reset_out_valid", {511'd0, out_valid}, 512'd0);
    check("t5_reset_quotient", quotient, 512'd0);
    do_op("t5_after", 512'hB, 256'h7, 512'd3, 255'd2, 1'b0, 766);

    for (int v = 0; v < 40; v++) begin
      db = (v < 4) ? v : int'($urandom_range(0, 255));
      da = int'($urandom_range(0, 255));
      b  = (rand256() & low_mask(db)) | (256'd1 << db);
      a  = rand256() & low_mask(da + 1);
      r  = rand256() & low_mask(db);
      do_op("t6_random", clmul(a, b) ^ {256'd0, r}, b, {256'd0, a}, r[254:0], 1'b0, 256 - db + 512);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
